// File: rtl/counter_stride.sv
// counter_stride: parametrised WIDTH-bit sequence generator with all/odd/even/custom
// stride modes, up/down direction, synchronous load, wrap-or-saturate boundary
// handling and a registered terminal-count pulse for cascading.

module counter_stride #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] RST_VAL  = '0,
   parameter bit               SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] step_val,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt_o,
   output logic             tc_o
);

   localparam logic [1:0] MODE_ALL    = 2'b00;
   localparam logic [1:0] MODE_ODD    = 2'b01;
   localparam logic [1:0] MODE_EVEN   = 2'b10;
   localparam logic [1:0] MODE_CUSTOM = 2'b11;

   localparam logic [WIDTH:0]   STEP_ONE = (WIDTH + 1)'(1);
   localparam logic [WIDTH:0]   STEP_TWO = (WIDTH + 1)'(2);
   localparam logic [WIDTH-1:0] MAX_VAL  = '1;
   localparam logic [WIDTH-1:0] EVEN_MAX = {{(WIDTH - 1){1'b1}}, 1'b0};
   localparam logic [WIDTH-1:0] ODD_MIN  = {{(WIDTH - 1){1'b0}}, 1'b1};

   logic [WIDTH:0]   step;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             over;
   logic             under;
   logic [WIDTH-1:0] upper_clamp;
   logic [WIDTH-1:0] lower_clamp;
   logic [WIDTH-1:0] next_cnt;
   logic             next_tc;

   // Pick the stride; odd/even modes take a single step when off-lattice so the
   // count snaps onto the requested parity in the counting direction.
   always_comb begin
      step = STEP_ONE;
      case (mode)
         MODE_ALL:    step = STEP_ONE;
         MODE_ODD:    step = cnt_o[0] ? STEP_TWO : STEP_ONE;
         MODE_EVEN:   step = cnt_o[0] ? STEP_ONE : STEP_TWO;
         MODE_CUSTOM: step = {1'b0, step_val};
         default:     step = STEP_ONE;
      endcase
   end

   // Compute the candidate next value one bit wider so the carry/borrow bit
   // flags overflow or underflow, then wrap or clamp it to the mode's boundary.
   always_comb begin
      sum         = {1'b0, cnt_o} + step;
      diff        = {1'b0, cnt_o} - step;
      over        = dir & sum[WIDTH];
      under       = ~dir & diff[WIDTH];
      upper_clamp = (mode == MODE_EVEN) ? EVEN_MAX : MAX_VAL;
      lower_clamp = (mode == MODE_ODD) ? ODD_MIN : '0;
      next_cnt    = dir ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
      if (SATURATE) begin
         if (over) begin
            next_cnt = upper_clamp;
         end else if (under) begin
            next_cnt = lower_clamp;
         end
      end
      next_tc = over | under;
   end

   // Count register: load beats enable beats hold; tc only pulses on an enabled
   // step that crossed a boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_o <= RST_VAL;
         tc_o  <= 1'b0;
      end else if (load) begin
         cnt_o <= load_val;
         tc_o  <= 1'b0;
      end else if (en) begin
         cnt_o <= next_cnt;
         tc_o  <= next_tc;
      end else begin
         tc_o  <= 1'b0;
      end
   end

endmodule

// File: doc/counter_stride.md
Name: counter_stride

Overview:
Parametrised successor to the team's fixed 8-bit odd counter. It generates a WIDTH-bit count sequence with a run-time selectable mode: all values, odd-only, even-only, or a custom stride. It supports up/down direction, count enable and synchronous load, and can either wrap or saturate at the boundaries. It serves as the general-purpose sequence/address generator for downstream blocks, and a terminal-count pulse lets it be cascaded.

Parameters:
WIDTH, 8, count width in bits; legal range 2..32.
RST_VAL, 0, value of cnt_o after reset; must fit in WIDTH bits.
SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp at the mode's boundary value.

Ports:
clk  input  1  single clock, rising-edge.
rst  input  1  asynchronous, active-low reset; assertion is immediate, de-assertion is synchronous to clk externally.
en  input  1  advances the count one step per cycle while high.
dir  input  1  1 = up, 0 = down.
mode  input  2  00 = all (step 1), 01 = odd, 10 = even, 11 = custom (step = step_val).
step_val  input  WIDTH  stride in custom mode; unsigned.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value loaded when load is high.
cnt_o  output  WIDTH  registered count.
tc_o  output  1  registered terminal-count pulse.

Behaviour:
- Reset (rst low, asynchronous): cnt_o = RST_VAL, tc_o = 0. Both hold until the first clk edge after rst rises. Reset mid-count aborts immediately with no partial update.
- Priority on each rising clk edge: load > en > hold.
- load = 1: cnt_o <= load_val verbatim, with no parity correction. tc_o <= 0. en, mode and dir are ignored that cycle.
- en = 0 and load = 0: cnt_o holds; tc_o <= 0.
- en = 1: next value N is computed in WIDTH+1 bits from cnt_o (C):
  - mode 00: N = C ± 1.
  - mode 01, C odd: N = C ± 2. C even: N = C ± 1 (snaps onto the odd lattice in the counting direction).
  - mode 10, C even: N = C ± 2. C odd: N = C ± 1 (snaps onto the even lattice).
  - mode 11: N = C ± step_val. step_val = 0 means hold; tc_o = 0.
  - "+" applies when dir = 1, "−" when dir = 0.
- Overflow: N > 2^WIDTH−1 (up). Underflow: N < 0 (down).
- SATURATE = 0: cnt_o <= N mod 2^WIDTH. Parity is preserved on wrap because 2^WIDTH is even.
- SATURATE = 1: on overflow/underflow, cnt_o <= clamp value. Otherwise cnt_o <= N.
  - Upper clamp: modes 00/11 = 2^WIDTH−1; mode 01 = 2^WIDTH−1; mode 10 = 2^WIDTH−2.
  - Lower clamp: modes 00/10/11 = 0; mode 01 = 1.
- tc_o: registered. It is 1 in exactly the cycle where cnt_o first shows a wrapped or clamped result, otherwise 0.
  - In saturate mode, each further enabled step that would exceed the boundary pulses tc_o again, so tc_o stays high while en is held at the clamp.
- Mode or dir change takes effect on the next enabled edge, with no pipeline delay. Latency from en to cnt_o change is 1 cycle.
- Simultaneous load + en + overflow condition: load wins and tc_o = 0.
- No combinational path from inputs to outputs.

Test Plan:
(All scenarios use WIDTH=8, RST_VAL=0 unless stated.)
1. Reset: hold rst low 2 cycles, release, en=0 → cnt_o=0 and tc_o=0 throughout. Assert rst low mid-count at cnt_o=37 → cnt_o=0 immediately, before the next clk edge.
2. Odd up wrap (SATURATE=0): mode=01, dir=1, en=1 from 0 → 1, 3, 5, …, 253, 255, 1. tc_o=1 only on the cycle cnt_o=1 after 255.
3. Even down wrap: load 4, then mode=10, dir=0, en=1 → 2, 0, 254 (tc_o=1), 252 (tc_o=0).
4. Mode switch snap: load 5, mode=10, dir=1 → 6, 8. Switch to mode=01 at 8 → 9, 11.
5. Custom saturate (SATURATE=1): load 200, mode=11, step_val=100, dir=1, en=1 → 255 with tc_o=1, then 255 with tc_o=1 again. Drop en → 255 held, tc_o=0. Also mode=01, dir=0 from 1 → clamps at 1 with tc_o=1.
6. Load priority: at cnt_o=254 with mode=00, dir=1, en=1, load=1, load_val=42 → cnt_o=42, tc_o=0. Next cycle → 43.
